// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
// State encoding, data-word width and wait-counter width.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: single shared index, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] words [2**DEPTH_LOG2];

    always_ff @(posedge CLK) begin
        if (we) begin
            words[idx] <= wdata;
        end
    end

    assign rdata = words[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states in front of a word array.
// Optional address-error checking is enabled by defining MEM_RESP_ERR_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for mem_read/mem_write; accepts and latches a request
// WAIT    | counting down wait states; write commits on the exit edge
// RESP    | one cycle: ack=1, busy=1, rdata/err valid; always returns IDLE
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              ack,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    op_write;
    logic [DEPTH_LOG2-1:0]   idx_lat;
    logic                    bad_lat;
    logic [WORD_W-1:0]       wdata_lat;

    logic                    req;
    logic [DEPTH_LOG2-1:0]   idx_in;
    logic                    bad_in;
    logic                    commit_idle;
    logic                    commit_wait;
    logic                    arr_we;
    logic [DEPTH_LOG2-1:0]   arr_idx;
    logic [WORD_W-1:0]       arr_wdata;
    logic [WORD_W-1:0]       arr_rdata;

    assign req    = mem_read | mem_write;
    assign idx_in = addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_ERR_EN
    assign bad_in = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != '0);
`else
    assign bad_in = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With zero wait states the write lands on the accepting edge, straight from the inputs.
    assign commit_idle = (state == ST_IDLE) && req && (WAIT_CYCLES == 0) && mem_write && !bad_in;
    assign commit_wait = (state == ST_WAIT) && (cnt == '0) && op_write && !bad_lat;
    assign arr_we      = !RST && (commit_idle || commit_wait);
    assign arr_idx     = (state == ST_IDLE) ? idx_in : idx_lat;
    assign arr_wdata   = (state == ST_IDLE) ? wdata  : wdata_lat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            idx_lat   <= '0;
            bad_lat   <= 1'b0;
            wdata_lat <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                op_write  <= mem_write;
                idx_lat   <= idx_in;
                bad_lat   <= bad_in;
                wdata_lat <= wdata;
                cnt       <= WAIT_LOAD;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    mem_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .CLK   (CLK),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign busy  = (state != ST_IDLE);
    assign ack   = (state == ST_RESP);
    assign rdata = (ack && !op_write && !bad_lat) ? arr_rdata : '0;

`ifdef MEM_RESP_ERR_EN
    assign err = ack && bad_lat;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0).
// Expectations for MEM_RESP_ERR_EN follow the same macro.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        busy, ack, err;

    logic        r0, w0;
    logic [31:0] a0, d0, rdata0;
    logic        busy0, ack0, err0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mem_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RST(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .ack(ack), .err(err)
    );

    mem_responder #(.DEPTH_LOG2(5), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst), .mem_read(r0), .mem_write(w0),
        .addr(a0), .wdata(d0), .rdata(rdata0), .busy(busy0), .ack(ack0), .err(err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance; optionally pokes a write during WAIT.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit poke);
        exp_t e;
        int   cyc;
        bit   got;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        e.rdata = er; e.err = ee;
        sb.push_back(e);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        cyc = 1; got = 1'b0;
        while (!got && cyc <= 20) begin
            check("busy", busy, 1);
            if (ack === 1'b1) begin
                got = 1'b1;
            end else begin
                check("idle_rdata", rdata, 0);
                check("idle_err", err, 0);
                if (poke && cyc == 1) begin
                    mem_write = 1'b1; addr = 32'h08; wdata = 32'hFFFF_FFFF;
                end
                @(posedge clk); #1;
                mem_write = 1'b0;
                cyc++;
            end
        end
        check("ack_seen", got, 1);
        e = sb.pop_front();
        if (got) begin
            check("latency", cyc, 3);
            check("rdata", rdata, e.rdata);
            check("err", err, e.err);
        end
        @(posedge clk); #1;
        check("busy_after", busy, 0);
        check("ack_after", ack, 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
        r0 = 0; w0 = 0; a0 = 0; d0 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy0", busy0, 0);
        check("rst_ack0", ack0, 0);

        req(0, 1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        req(1, 0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
        req(1, 0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        req(0, 1, 32'h04, 32'hCAFE_0001, 32'h0, 1'b0, 0);
`ifdef MEM_RESP_ERR_EN
        req(0, 1, 32'h84, 32'h1234_5678, 32'h0, 1'b1, 0);
        req(1, 0, 32'h04, 32'h0, 32'hCAFE_0001, 1'b0, 0);
        req(1, 0, 32'h09, 32'h0, 32'h0, 1'b1, 0);
`else
        req(0, 1, 32'h84, 32'h1234_5678, 32'h0, 1'b0, 0);
        req(1, 0, 32'h04, 32'h0, 32'h1234_5678, 1'b0, 0);
        req(1, 0, 32'h09, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
`endif

        req(1, 1, 32'h10, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
        req(1, 0, 32'h10, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);

        req(0, 1, 32'h0C, 32'h1111_2222, 32'h0, 1'b0, 0);
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h0C; wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        check("abort_in_wait", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ack", ack, 0);
        check("abort_rdata", rdata, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_ack", ack, 0);
        end
        req(1, 0, 32'h0C, 32'h0, 32'h1111_2222, 1'b0, 0);

        @(negedge clk);
        w0 = 1'b1; a0 = 32'h20; d0 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        w0 = 1'b0;
        check("w0_ack", ack0, 1);
        check("w0_busy", busy0, 1);
        check("w0_rdata", rdata0, 0);
        @(posedge clk); #1;
        check("w0_ack_after", ack0, 0);
        check("w0_busy_after", busy0, 0);

        @(negedge clk);
        r0 = 1'b1; a0 = 32'h20;
        @(posedge clk); #1;
        check("r0_ack1", ack0, 1);
        check("r0_rdata1", rdata0, 32'h0BAD_F00D);
        check("r0_err1", err0, 0);
        @(posedge clk); #1;
        check("r0_gap_ack", ack0, 0);
        check("r0_gap_busy", busy0, 0);
        check("r0_gap_rdata", rdata0, 0);
        @(posedge clk); #1;
        r0 = 1'b0;
        check("r0_ack2", ack0, 1);
        check("r0_rdata2", rdata0, 32'h0BAD_F00D);
        @(posedge clk); #1;
        check("r0_ack_end", ack0, 0);
        check("r0_busy_end", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5, meaning log2 of the number of 32-bit words stored (32 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, meaning the number of wait-state cycles inserted before each response.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port mem_read, input, 1 bit: read request from the processor.
REQ-006 SHALL have port mem_write, input, 1 bit: write request from the processor.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port rdata, output, 32 bits: read data, valid while ack=1.
REQ-010 SHALL have port busy, output, 1 bit: a request is in progress and new requests are ignored.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle pulse marking request completion.
REQ-012 SHALL have port err, output, 1 bit: error flag, valid while ack=1 (see Configuration).

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE, mem_read or mem_write high SHALL accept the request, latch addr, wdata and the operation, and set busy=1 on the next cycle.
REQ-015 With mem_read and mem_write both high, the request SHALL be treated as a write.
REQ-016 After acceptance the FSM SHALL go to WAIT for exactly WAIT_CYCLES cycles via a down-counter; WAIT_CYCLES=0 SHALL go directly from IDLE to RESP.
REQ-017 Latency: a request accepted at edge N SHALL have ack=1 during cycle N+1+WAIT_CYCLES.
REQ-018 RESP SHALL last exactly one cycle with ack=1 and busy=1; the next state SHALL always be IDLE.
REQ-019 A write SHALL commit to the storage word on the edge entering RESP; rdata SHALL then hold 0.
REQ-020 A read SHALL present the addressed word on rdata during RESP, including data written by an immediately preceding write.
REQ-021 Word index SHALL be latched addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above DEPTH_LOG2+1 SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-022 Request inputs SHALL be ignored in WAIT and RESP; a request still held in the cycle after RESP (IDLE) SHALL be accepted as a new request.
REQ-023 Outside RESP, ack, err and rdata SHALL be 0.

Reset
REQ-024 RST=1 SHALL force state IDLE, wait counter 0, busy=0, ack=0, err=0 and rdata=0 on the next edge.
REQ-025 Reset in WAIT SHALL abort the request, and a pending write SHALL NOT be committed.
REQ-026 Storage contents SHALL NOT be affected by reset.

Configuration
REQ-027 Macro MEM_RESP_ERR_EN defined: err=1 in RESP if latched addr[1:0]!=0 or any addr bit above DEPTH_LOG2+1 is set; an erroring write SHALL NOT commit, and an erroring read SHALL return rdata=0.
REQ-028 Macro MEM_RESP_ERR_EN undefined: err SHALL be tied to 0 and addresses SHALL wrap per REQ-021.

Structure
REQ-029 Package mem_resp_pkg SHALL hold the FSM state typedef, the word-width constant (32) and the wait-counter width (4).
REQ-030 Storage SHALL be a sub-module mem_resp_array: a single-port synchronous-write, asynchronous-read word array.

Verification
REQ-031 Write case: WAIT_CYCLES=2, write addr=0x08 data=0xDEADBEEF at edge N -> busy=1 in N+1..N+3, ack=1 in N+3 only, rdata=0.
REQ-032 Read-after-write: read addr=0x08 accepted the cycle after REQ-031's ack -> ack 3 cycles later with rdata=0xDEADBEEF, err=0.
REQ-033 Wrap: DEPTH_LOG2=5, write 0x12345678 to addr=0x84, read addr=0x04 -> rdata=0x12345678 (macro off); with macro on, the write gives err=1 and word 1 is unchanged.
REQ-034 Simultaneous: mem_read=mem_write=1, addr=0x10, wdata=0xA5A5A5A5 -> write performed; a later read of 0x10 returns 0xA5A5A5A5.
REQ-035 Reset mid-op: write 0x0000FFFF to addr=0x0C, assert RST in the first WAIT cycle -> no ack, busy=0 after the edge, and a later read of 0x0C returns the old value.
REQ-036 WAIT_CYCLES=0: read accepted at edge N -> ack in cycle N+1; back-to-back held read -> second ack in cycle N+3.
